// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the pipeline data-memory interface.
// Accepts one MEM-stage load/store at a time over a valid/ready handshake,
// waits a fixed LATENCY, then produces a one-cycle response strobe. While an
// access is in flight the stall output freezes the IF..MEM stages.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject word-misaligned
// requests (rsp_err=1, no write). Without it, addr[1:0] is ignored.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept;
  logic              enter_resp;

  // Captured request (only the address bits that select a word, plus the
  // byte-offset bits used by the alignment check).
  logic              cap_we;
  logic [IDX_W+1:0]  cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  // The access that is about to enter RESP. With LATENCY=0 the request goes
  // straight from IDLE to RESP on the accepting edge, before the capture
  // registers have loaded, so the live request must be used in that case.
  logic              acc_we;
  logic [IDX_W+1:0]  acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_misaligned;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Upper address bits are deliberately ignored: addresses wrap modulo depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:IDX_W+2];

  // State register, latency counter and captured request.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr[IDX_W+1:0];
        cap_wdata <= req_wdata;
      end
    end
  end

  // Next-state logic and handshake/stall outputs.
  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    stall      = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_nxt = LAT;
          if (LAT == 4'd0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt <= 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
          cnt_nxt    = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the access that commits on the edge entering RESP.
  always_comb begin
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr[IDX_W+1:0];
      acc_wdata = req_wdata;
    end
  end

  assign acc_idx = acc_addr[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_misaligned = |acc_addr[1:0];
`else
  logic unused_align_bits;
  assign unused_align_bits = ^acc_addr[1:0];
  assign acc_misaligned    = 1'b0;
`endif

  // A write is blocked while reset is asserted so an aborted store never lands.
  assign mem_we = enter_resp && acc_we && !acc_misaligned && !rst;

  // Storage array: committed on the edge that enters RESP.
  // NOTE: the memory has no reset branch; clearing it would turn the array
  // into flops and its contents are not defined to survive or clear on reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Registered response payload; holds until the next RESP or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= acc_misaligned;
      rsp_rdata <= (acc_we || acc_misaligned) ? '0 : mem[acc_idx];
    end
  end

endmodule
